// File: rtl/btn_cond_pkg.sv
// Shared types and helpers for the button conditioner: FSM state encoding,
// counter sizing, and the small parameter set used in simulation.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    // Short timing values that keep simulation runs brief.
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 3;

    // Width needed to hold the largest of the three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous board input.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic s1;

    // Capture the raw input, then re-register it to settle metastability.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep s1 -> q a true two-stage shift.
        if (RESET) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push-button / switch into a clean level, one-cycle
// PRESS / RELEASE strobes, and a press-toggled enable.
// Optional macro BTN_REPEAT_EN adds auto-repeat PRESS strobes while held.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_IN,
    output logic LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic TOGGLE
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s2;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          level_n, press_n, release_n, toggle_n;

`ifdef BTN_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    // rphase=0: waiting out the initial delay; rphase=1: periodic repeats.
    logic [CW-1:0] rcnt, rcnt_n;
    logic          rphase, rphase_n;
`endif

    sync_2ff u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (BTN_IN),
        .q     (s2)
    );

    // Next-state, counter and output decode for the debounce FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_n   = state;
        cnt_n     = cnt;
        level_n   = LEVEL;
        press_n   = 1'b0;
        release_n = 1'b0;
        toggle_n  = TOGGLE;
`ifdef BTN_REPEAT_EN
        rcnt_n    = rcnt;
        rphase_n  = rphase;
`endif
        case (state)
            S_LOW: begin
                if (s2) begin
                    state_n = S_RISE;
                    cnt_n   = CW'(1);
                end else begin
                    cnt_n   = '0;
                end
`ifdef BTN_REPEAT_EN
                rcnt_n   = '0;
                rphase_n = 1'b0;
`endif
            end
            S_RISE: begin
                if (!s2) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n  = S_HIGH;
                    cnt_n    = '0;
                    level_n  = 1'b1;
                    press_n  = 1'b1;
                    toggle_n = ~TOGGLE;
                end else begin
                    cnt_n   = cnt + CW'(1);
                end
`ifdef BTN_REPEAT_EN
                rcnt_n   = '0;
                rphase_n = 1'b0;
`endif
            end
            S_HIGH: begin
                if (!s2) begin
                    state_n = S_FALL;
                    cnt_n   = CW'(1);
                end else begin
                    cnt_n   = '0;
`ifdef BTN_REPEAT_EN
                    // Repeat timing advances only while the button is held.
                    if (!rphase) begin
                        if (rcnt == RD_LAST) begin
                            press_n  = 1'b1;
                            rcnt_n   = '0;
                            rphase_n = 1'b1;
                        end else begin
                            rcnt_n   = rcnt + CW'(1);
                        end
                    end else begin
                        if (rcnt == RP_LAST) begin
                            press_n  = 1'b1;
                            rcnt_n   = '0;
                        end else begin
                            rcnt_n   = rcnt + CW'(1);
                        end
                    end
`endif
                end
            end
            S_FALL: begin
                if (s2) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n   = S_LOW;
                    cnt_n     = '0;
                    level_n   = 1'b0;
                    release_n = 1'b1;
`ifdef BTN_REPEAT_EN
                    rcnt_n    = '0;
                    rphase_n  = 1'b0;
`endif
                end else begin
                    cnt_n   = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_LOW;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_LOW;
            cnt     <= '0;
            LEVEL   <= 1'b0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            TOGGLE  <= 1'b0;
`ifdef BTN_REPEAT_EN
            rcnt    <= '0;
            rphase  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            LEVEL   <= level_n;
            PRESS   <= press_n;
            RELEASE <= release_n;
            TOGGLE  <= toggle_n;
`ifdef BTN_REPEAT_EN
            rcnt    <= rcnt_n;
            rphase  <= rphase_n;
`endif
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus
// randomized button activity checked every cycle against a run-length model.
module tb_button_conditioner;
    import btn_cond_pkg::*;

    localparam int D  = DEF_DEBOUNCE_CYCLES;
    localparam int RD = DEF_REPEAT_DELAY;
    localparam int RP = DEF_REPEAT_PERIOD;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic BTN_IN = 1'b0;
    logic LEVEL, PRESS, RELEASE, TOGGLE;

    int n_checks = 0;
    int n_fail   = 0;
    int n_press  = 0;
    int n_release = 0;

    // Reference model state
    bit pipe0 = 1'b0, pipe1 = 1'b0;
    bit acc = 1'b0;
    int run = 0;
    int age = 0;
    bit exp_level = 1'b0, exp_press = 1'b0, exp_release = 1'b0, exp_toggle = 1'b0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .BTN_IN  (BTN_IN),
        .LEVEL   (LEVEL),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .TOGGLE  (TOGGLE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a new level is accepted once the synchronized input has
    // disagreed with the accepted level for D consecutive samples.
    always @(posedge CLK) begin
        bit sample;
        if (RESET) begin
            pipe0 = 1'b0; pipe1 = 1'b0;
            acc = 1'b0; run = 0; age = 0;
            exp_level = 1'b0; exp_press = 1'b0; exp_release = 1'b0; exp_toggle = 1'b0;
        end else begin
            sample = pipe1;
            pipe1  = pipe0;
            pipe0  = BTN_IN;
            exp_press   = 1'b0;
            exp_release = 1'b0;
            if (sample != acc) run++;
            else run = 0;
            if (run == D) begin
                acc = sample;
                run = 0;
                if (acc) begin
                    exp_press  = 1'b1;
                    exp_toggle = ~exp_toggle;
                    age = 0;
                end else begin
                    exp_release = 1'b1;
                end
            end else if (REP_EN && acc && sample) begin
                age++;
                if (age == RD || (age > RD && (age - RD) % RP == 0)) exp_press = 1'b1;
            end
            exp_level = acc;
        end
    end

    // Compare every output every cycle, and tally strobes seen on the DUT.
    always @(negedge CLK) begin
        check("level",   LEVEL,   exp_level);
        check("press",   PRESS,   exp_press);
        check("release", RELEASE, exp_release);
        check("toggle",  TOGGLE,  exp_toggle);
        if (PRESS === 1'b1) n_press++;
        if (RELEASE === 1'b1) n_release++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Edge index (0 = next edge) after which the chosen strobe is first high.
    task automatic wait_strobe(input int which, input int limit, output int k);
        k = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge CLK);
            #1;
            if ((which == 0 && PRESS === 1'b1) || (which == 1 && RELEASE === 1'b1)) begin
                k = i;
                break;
            end
        end
        @(negedge CLK);
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        cycles(n);
        RESET = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p0, r0;
        int exp_tog[4];
        exp_tog = '{1, 0, 1, 0};

        // 1: reset with button held, then release reset -> press at R+1+D
        BTN_IN = 1'b1;
        RESET  = 1'b1;
        cycles(3);
        check("t1_level_in_reset", LEVEL, 0);
        RESET = 1'b0;
        wait_strobe(0, 20, k);
        check("t1_press_latency", k, D + 1);
        check("t1_level", LEVEL, 1);
        check("t1_toggle", TOGGLE, 1);

        // 2: clean press/release latency from first sampling edge
        BTN_IN = 1'b0;
        cycles(10);
        BTN_IN = 1'b1;
        wait_strobe(0, 20, k);
        check("t2_press_latency", k, D + 1);
        cycles(1);
        check("t2_press_one_cycle", PRESS, 0);
        cycles(4);
        BTN_IN = 1'b0;
        wait_strobe(1, 20, k);
        check("t2_release_latency", k, D + 1);
        cycles(1);
        check("t2_release_one_cycle", RELEASE, 0);
        cycles(4);

        // 3: bounce shorter than the debounce window is ignored
        p0 = n_press; r0 = n_release;
        BTN_IN = 1'b1; cycles(3);
        BTN_IN = 1'b0; cycles(1);
        BTN_IN = 1'b1; cycles(2);
        BTN_IN = 1'b0; cycles(10);
        check("t3_no_press", n_press - p0, 0);
        check("t3_no_release", n_release - r0, 0);
        check("t3_level", LEVEL, 0);

        // 4: four clean presses toggle 1,0,1,0
        do_reset(2);
        p0 = n_press; r0 = n_release;
        for (int i = 0; i < 4; i++) begin
            BTN_IN = 1'b1;
            cycles(8);
            check("t4_toggle", TOGGLE, exp_tog[i]);
            BTN_IN = 1'b0;
            cycles(8);
        end
        check("t4_press_count", n_press - p0, 4);
        check("t4_release_count", n_release - r0, 4);

        // 5: reset pulse mid-debounce discards the count
        BTN_IN = 1'b1;
        cycles(3);
        RESET = 1'b1;
        cycles(1);
        RESET = 1'b0;
        wait_strobe(0, 20, k);
        check("t5_press_after_reset", k, D + 1);
        check("t5_level", LEVEL, 1);
        BTN_IN = 1'b0;
        cycles(10);

`ifdef BTN_REPEAT_EN
        // 6: auto-repeat while held
        begin
            int q[$];
            int exp_q[5];
            exp_q = '{8, 11, 14, 17, 20};
            do_reset(2);
            BTN_IN = 1'b1;
            k = -1;
            for (int i = 0; i < 20; i++) begin
                @(posedge CLK); #1;
                if (PRESS === 1'b1) begin k = i; break; end
            end
            check("t6_first_press", k, D + 1);
            for (int i = 1; i <= 22; i++) begin
                @(posedge CLK); #1;
                if (PRESS === 1'b1) q.push_back(i);
            end
            check("t6_repeat_count", q.size(), 5);
            for (int i = 0; i < 5; i++)
                check("t6_repeat_edge", (i < q.size()) ? q[i] : -1, exp_q[i]);
            check("t6_toggle_once", TOGGLE, 1);
            @(negedge CLK);
            BTN_IN = 1'b0;
            cycles(10);
        end
`endif

        // Random activity: runs mostly near the debounce window, some long holds,
        // occasional reset pulses; the per-cycle checker does the comparing.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                BTN_IN = ~BTN_IN;
                if ($urandom_range(0, 7) == 0) cycles($urandom_range(10, 30));
                else cycles($urandom_range(1, 7));
            end
        end
        BTN_IN = 1'b0;
        cycles(10);

        $display("test done: total=%0d bad=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
